// File: rtl/sp_tc_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its job front end,
// tensor core, operand buffer and result consumer.
interface sp_tc_tile_scheduler_if #(
  parameter int TILE_W = 8,
  parameter int ADDR_W = 16
);
  logic              job_valid;
  logic              job_ready;
  logic [TILE_W-1:0] job_num_tiles;
  logic [ADDR_W-1:0] job_base_addr;
  logic              core_start;
  logic              core_fetch_done;
  logic              core_write_back;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              res_valid;
  logic              res_ready;
  logic [TILE_W-1:0] res_tile_idx;
  logic              job_done;
  logic              err_timeout;

  modport master (
    input  job_valid, job_num_tiles, job_base_addr, core_write_back, rd_ack, res_ready,
    output job_ready, core_start, core_fetch_done, rd_req, rd_addr, res_valid,
           res_tile_idx, job_done, err_timeout
  );

  modport slave (
    output job_valid, job_num_tiles, job_base_addr, core_write_back, rd_ack, res_ready,
    input  job_ready, core_start, core_fetch_done, rd_req, rd_addr, res_valid,
           res_tile_idx, job_done, err_timeout
  );
endinterface

// File: rtl/sp_tc_tile_scheduler.sv
// Walks the sparse tensor core through a job of N tiles: start, operand fetch,
// write-back wait (with watchdog) and result hand-off per tile.
module sp_tc_tile_scheduler #(
  parameter int TILE_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int FETCH_BEATS = 2,
  parameter int BEAT_W      = 1,
  parameter int TIMEOUT     = 1024,
  parameter int TO_W        = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  sp_tc_tile_scheduler_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_FDONE   = 3'd3;
  localparam logic [2:0] S_WAIT_WB = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);
  localparam logic [TO_W-1:0]   WD_LAST   = TO_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [TILE_W-1:0] num_tiles;
  logic [TILE_W-1:0] tile_idx;
  logic [ADDR_W-1:0] addr;
  logic [BEAT_W-1:0] beat;
  logic [TO_W-1:0]   wd;
  logic              err;

  // Tiles occupy consecutive FETCH_BEATS-sized blocks, so the read address
  // simply advances by one per accepted beat and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      num_tiles <= '0;
      tile_idx  <= '0;
      addr      <= '0;
      beat      <= '0;
      wd        <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.job_valid) begin
            num_tiles <= bus.job_num_tiles;
            addr      <= bus.job_base_addr;
            tile_idx  <= '0;
            err       <= 1'b0;
            state     <= (bus.job_num_tiles == '0) ? S_FINISH : S_START;
          end
        end
        S_START: begin
          beat  <= '0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.rd_ack) begin
            addr <= addr + ADDR_W'(1);
            if (beat == LAST_BEAT) begin
              state <= S_FDONE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        S_FDONE: begin
          wd    <= '0;
          state <= S_WAIT_WB;
        end
        S_WAIT_WB: begin
          if (bus.core_write_back) begin
            state <= S_DRAIN;
          end else if (wd == WD_LAST) begin
            err   <= 1'b1;
            state <= S_FINISH;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        S_DRAIN: begin
          if (bus.res_ready) begin
            if (tile_idx == num_tiles - TILE_W'(1)) begin
              state <= S_FINISH;
            end else begin
              tile_idx <= tile_idx + TILE_W'(1);
              state    <= S_START;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.job_ready       = (state == S_IDLE);
  assign bus.core_start      = (state == S_START);
  assign bus.core_fetch_done = (state == S_FDONE);
  assign bus.rd_req          = (state == S_FETCH);
  assign bus.rd_addr         = addr;
  assign bus.res_valid       = (state == S_DRAIN);
  assign bus.res_tile_idx    = tile_idx;
  assign bus.job_done        = (state == S_FINISH);
  assign bus.err_timeout     = err;

endmodule
